pkt_merge_arbiter: RTL and testbench
====================================

# pkt_merge_arbiter

Packet-granular two-input merge arbiter for the 134b packet bus. It sits between two packet producers and a single 134b consumer: the ingress/GMII stream and the CPU-generated stream feeding the user module, or the user-module output feeding GMII TX. Each input is buffered in a commit-based FIFO, so only complete, well-formed packets become eligible. Complete packets are granted round-robin and emitted whole, one word per cycle, with no interleaving between packets.

## Interface
- `DEPTH`, default 128: words per input FIFO. Power of 2, at least `MAX_PKT_WORDS`.
- `MAX_PKT_WORDS`, default 96: largest accepted packet in 16-byte words (1518 B ⇒ 95 words).
- `clk` in, 1: single clock. All logic is on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `in0_valid` in, 1: word valid on input 0. No backpressure.
- `in0_data` in, 134: word on input 0.
  - [133:132] head tag: 01 head, 10 tail, 11 single-word packet, 00 middle.
  - [131:128] valid tag.
  - [127:0] data.
- `in1_valid` in, 1: as `in0_valid`, for input 1.
- `in1_data` in, 134: as `in0_data`, for input 1.
- `out_valid` out, 1: output word valid. Registered.
- `out_data` out, 134: output word. Registered. Carried unmodified from the input.
- `out_src` out, 1: source input of the current output word.
- `drop_cnt0` out, 16: packets dropped on input 0. Saturating.
- `drop_cnt1` out, 16: packets dropped on input 1. Saturating.

## Operation
- Each input FIFO has three pointers, each log2(DEPTH)+1 bits wide: `wr_ptr`, `cmt_ptr` (commit) and `rd_ptr`.
  - Free space is DEPTH − (`wr_ptr` − `rd_ptr`), modulo 2^(log2(DEPTH)+1).
  - Committed data is the range `rd_ptr` .. `cmt_ptr`.
- Ingress FSM, one per input, with states IDLE, RECV and DISCARD:
  - IDLE, head (01) arrives:
    - If free ≥ `MAX_PKT_WORDS`: write it and go to RECV.
    - Otherwise: drop the packet, increment the drop counter, go to DISCARD.
  - IDLE, single-word packet (11) arrives:
    - If free ≥ 1: write it and commit (`cmt_ptr` ← `wr_ptr`+1).
    - Otherwise: drop and count.
  - IDLE, tag 00 or 10: discard silently; not counted.
  - RECV, tag 00: write.
  - RECV, tag 10: write, commit, go to IDLE.
  - RECV, the word would become word `MAX_PKT_WORDS`+1: roll back (`wr_ptr` ← `cmt_ptr`), count a drop, go to DISCARD.
  - RECV, new head (01 or 11) arrives: roll back and count the partial packet as a drop. Then process the new head exactly as in IDLE during the same cycle.
  - DISCARD: ignore words until a tag 10, which returns to IDLE. A head arriving in DISCARD is processed as in IDLE.
- Egress scheduler with states IDLE and SEND:
  - Input k is eligible when `rd_ptr`k ≠ `cmt_ptr`k.
  - IDLE: if exactly one input is eligible, grant it. If both are eligible, grant the input ≠ `last_grant`. Go to SEND.
  - SEND: read one word per cycle from the granted FIFO and present it on `out_data` with `out_valid`=1 and `out_src` = grant.
  - SEND: the word with tag 10 or 11 is the last. `last_grant` ← grant, then return to IDLE.
  - A granted packet is never preempted.
- Drop counters saturate at 0xFFFF.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0, drop counters 0.
  - All pointers 0.
  - Both FSMs in IDLE.
  - `last_grant`=1, so input 0 wins the first tie.
- Latency: a tail (or 11) word sampled at edge E is committed at E. The scheduler sees it at E+1. The first word of that packet is on the output after edge E+2.
- Output packets are contiguous: `out_valid`=1 on every cycle from head through tail.
- At least one `out_valid`=0 cycle separates consecutive output packets (the IDLE cycle).
- A write and a read on the same FIFO in the same cycle are both performed.
- Free space is evaluated with `rd_ptr` as of the start of the cycle.
- Simultaneous heads on both inputs are handled independently; no ingress conflict.
- Reset asserted mid-packet: all state clears immediately; every partial and committed packet is lost. After release, words arriving before the next head are discarded.

## Test plan
- Single input: a 4-word packet on in0 (01, 00, 00, 10). `out_valid` goes high 2 cycles after the tail, stays high for 4 cycles, `out_data` is bit-identical, `out_src`=0.
- Contention: 3-word packets on in0 and in1 committed in the same cycle. Output is the in0 packet, one idle cycle, then the in1 packet. A repeat of the same pair now yields in1 first if `last_grant` was 0 at the tie.
- Oversize: with `MAX_PKT_WORDS`=8, a 9-word packet on in1. Nothing appears on the output and `drop_cnt1`=1. A following 2-word packet is forwarded intact.
- Missing tail: in0 sends 01, 00, then 01, 10. `drop_cnt0`=1 and only the 2-word packet (01, 10) is output.
- FIFO full: with `DEPTH`=16, `MAX_PKT_WORDS`=8, output stalled by continuous in1 traffic. A third 8-word in0 packet whose head sees free < 8 is dropped and `drop_cnt0` increments. Single-word (11) packets still pass while free ≥ 1.
- Reset mid-SEND: assert `rst_n`=0 during word 2 of a 5-word output. `out_valid` drops to 0 immediately and counters read 0. After release, trailing 00/10 words are ignored and the next full packet is forwarded.

Source files
------------

// File: rtl/pkt_merge_arbiter.sv
// pkt_merge_arbiter: packet-granular two-input merge arbiter for the 134b bus.
//
// Each input feeds a commit-based FIFO (pkt_merge_fifo). Only complete,
// well-formed packets become visible to the egress scheduler. The scheduler
// grants complete packets round-robin and emits each one whole, one word per
// cycle, with at least one idle cycle between packets.
//
// Ports:
//   clk, rst_n             single clock, asynchronous active-low reset
//   in0_valid, in0_data    input 0 word stream (no backpressure)
//   in1_valid, in1_data    input 1 word stream (no backpressure)
//   out_valid, out_data    registered output word stream
//   out_src                source input of the current output word
//   drop_cnt0, drop_cnt1   saturating per-input dropped-packet counters
//
// Word layout: [133:132] tag (01 head, 00 middle, 10 tail, 11 single),
//              [131:128] valid tag, [127:0] data.

module pkt_merge_fifo #(
    parameter int DEPTH         = 128,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [133:0] in_data,
    input  logic         rd_en,
    output logic         pending,
    output logic [133:0] rd_word,
    output logic [15:0]  drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_PKT_WORDS + 1);

    localparam logic [1:0] ING_IDLE    = 2'd0;
    localparam logic [1:0] ING_RECV    = 2'd1;
    localparam logic [1:0] ING_DISCARD = 2'd2;

    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [PW-1:0] P_DEPTH = PW'(DEPTH);
    localparam logic [PW-1:0] P_MAX   = PW'(MAX_PKT_WORDS);
    localparam logic [LW-1:0] L_ONE   = LW'(1);
    localparam logic [LW-1:0] L_MAX   = LW'(MAX_PKT_WORDS);

    logic [133:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr;
    logic [1:0]    state;
    logic [LW-1:0] len;

    logic [1:0]    nxt_state;
    logic [PW-1:0] nxt_wr, nxt_cmt, base, free;
    logic [LW-1:0] nxt_len;
    logic          wr_en;
    logic [1:0]    drop_inc;
    logic [1:0]    tag;
    logic [16:0]   drop_sum;

    assign pending  = (rd_ptr != cmt_ptr);
    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign tag      = in_data[133:132];
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

    // tag[0] marks a packet start (01/11), tag[1] marks a packet end (10/11).
    // A head arriving mid-packet first rolls back to the commit point, so the
    // free-space check for the new head runs against the rolled-back pointer;
    // that cycle can count two drops (the partial packet and the new head).
    always_comb begin
        nxt_state = state;
        nxt_wr    = wr_ptr;
        nxt_cmt   = cmt_ptr;
        nxt_len   = len;
        wr_en     = 1'b0;
        drop_inc  = 2'd0;
        base      = wr_ptr;
        free      = '0;
        if (in_valid) begin
            if (tag[0]) begin
                if (state == ING_RECV) begin
                    base     = cmt_ptr;
                    drop_inc = 2'd1;
                end
                free      = P_DEPTH - (base - rd_ptr);
                nxt_wr    = base;
                nxt_state = ING_IDLE;
                if (tag[1]) begin
                    if (free != '0) begin
                        wr_en   = 1'b1;
                        nxt_wr  = base + P_ONE;
                        nxt_cmt = base + P_ONE;
                    end else begin
                        drop_inc = drop_inc + 2'd1;
                    end
                end else begin
                    if (free >= P_MAX) begin
                        wr_en     = 1'b1;
                        nxt_wr    = base + P_ONE;
                        nxt_len   = L_ONE;
                        nxt_state = ING_RECV;
                    end else begin
                        drop_inc  = drop_inc + 2'd1;
                        nxt_state = ING_DISCARD;
                    end
                end
            end else if (state == ING_RECV) begin
                if (len == L_MAX) begin
                    nxt_wr    = cmt_ptr;
                    drop_inc  = 2'd1;
                    nxt_state = ING_DISCARD;
                end else begin
                    wr_en   = 1'b1;
                    nxt_wr  = wr_ptr + P_ONE;
                    nxt_len = len + L_ONE;
                    if (tag[1]) begin
                        nxt_cmt   = wr_ptr + P_ONE;
                        nxt_state = ING_IDLE;
                    end
                end
            end else if (state == ING_DISCARD && tag[1]) begin
                nxt_state = ING_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[base[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ING_IDLE;
            wr_ptr   <= '0;
            cmt_ptr  <= '0;
            rd_ptr   <= '0;
            len      <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= nxt_state;
            wr_ptr   <= nxt_wr;
            cmt_ptr  <= nxt_cmt;
            len      <= nxt_len;
            drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
            if (rd_en) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
        end
    end
endmodule

module pkt_merge_arbiter #(
    parameter int DEPTH         = 128,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_valid,
    input  logic [133:0] in0_data,
    input  logic         in1_valid,
    input  logic [133:0] in1_data,
    output logic         out_valid,
    output logic [133:0] out_data,
    output logic         out_src,
    output logic [15:0]  drop_cnt0,
    output logic [15:0]  drop_cnt1
);
    localparam logic EG_IDLE = 1'b0;
    localparam logic EG_SEND = 1'b1;

    logic         eg_state, grant, last_grant;
    logic         pend0, pend1, rd_en0, rd_en1;
    logic [133:0] word0, word1, sel_word;

    pkt_merge_fifo #(.DEPTH(DEPTH), .MAX_PKT_WORDS(MAX_PKT_WORDS)) u_fifo0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in0_valid), .in_data(in0_data),
        .rd_en(rd_en0), .pending(pend0), .rd_word(word0), .drop_cnt(drop_cnt0)
    );

    pkt_merge_fifo #(.DEPTH(DEPTH), .MAX_PKT_WORDS(MAX_PKT_WORDS)) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in1_valid), .in_data(in1_data),
        .rd_en(rd_en1), .pending(pend1), .rd_word(word1), .drop_cnt(drop_cnt1)
    );

    always_comb begin
        rd_en0   = (eg_state == EG_SEND) && !grant;
        rd_en1   = (eg_state == EG_SEND) && grant;
        sel_word = grant ? word1 : word0;
    end

    // Bit 133 is set for both tail (10) and single (11): the packet's last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eg_state   <= EG_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
        end else begin
            case (eg_state)
                EG_IDLE: begin
                    out_valid <= 1'b0;
                    if (pend0 || pend1) begin
                        eg_state <= EG_SEND;
                        grant    <= (pend0 && pend1) ? ~last_grant : pend1;
                    end
                end
                default: begin
                    out_valid <= 1'b1;
                    out_data  <= sel_word;
                    out_src   <= grant;
                    if (sel_word[133]) begin
                        last_grant <= grant;
                        eg_state   <= EG_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_merge_arbiter.sv
// tb_pkt_merge_arbiter: scoreboard bench for pkt_merge_arbiter with
// DEPTH=16, MAX_PKT_WORDS=8. Stimulus pushes expected {src, word} entries;
// the monitor pops and compares each output word and checks packet framing.

module tb_pkt_merge_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_valid, in1_valid;
    logic [133:0] in0_data, in1_data;
    logic         out_valid, out_src;
    logic [133:0] out_data;
    logic [15:0]  drop_cnt0, drop_cnt1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [134:0] exp_q [$];

    pkt_merge_arbiter #(.DEPTH(16), .MAX_PKT_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_data(in1_data),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [134:0] act, input logic [134:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [1:0] tg(input int i, input int n);
        if (n == 1) return 2'b11;
        if (i == 0) return 2'b01;
        if (i == n - 1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [133:0] mk(input logic [1:0] tag, input logic [7:0] id, input int idx);
        return {tag, 4'hA, 104'h0, id, 16'(idx)};
    endfunction

    function automatic void push_pkt(input logic src, input logic [7:0] id, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({src, mk(tg(i, n), id, i)});
    endfunction

    task automatic step(input logic v0, input logic [133:0] d0, input logic v1, input logic [133:0] d1);
        in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk(name, 135'(exp_q.size()), 135'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output word and checks framing.
    initial begin
        bit open = 1'b0;
        bit prev_last = 1'b0;
        logic [134:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                open = 1'b0; prev_last = 1'b0;
            end else begin
                if (open) chk("contiguous", 135'(out_valid), 135'(1));
                if (prev_last) chk("gap", 135'(out_valid), 135'(0));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_word: got %h expected none", {out_src, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", {out_src, out_data}, e);
                    end
                    open = !out_data[133];
                    prev_last = out_data[133];
                end else begin
                    open = 1'b0; prev_last = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 135'(out_valid), 135'(0));
        chk("rst_out_data", 135'(out_data), 135'(0));
        chk("rst_out_src", 135'(out_src), 135'(0));
        chk("rst_drop0", 135'(drop_cnt0), 135'(0));
        chk("rst_drop1", 135'(drop_cnt1), 135'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Contention after reset: last_grant=1, so in0 wins the tie.
        push_pkt(1'b0, 8'h10, 3);
        push_pkt(1'b1, 8'h11, 3);
        for (int i = 0; i < 3; i++) step(1'b1, mk(tg(i, 3), 8'h10, i), 1'b1, mk(tg(i, 3), 8'h11, i));
        drain("contend_a");

        // Single 4-word packet on in0 with latency check.
        push_pkt(1'b0, 8'h20, 4);
        for (int i = 0; i < 4; i++) step(1'b1, mk(tg(i, 4), 8'h20, i), 1'b0, '0);
        @(posedge clk); #1;
        chk("lat_e1_valid", 135'(out_valid), 135'(0));
        @(posedge clk); #1;
        chk("lat_e2_valid", 135'(out_valid), 135'(1));
        chk("lat_e2_src", 135'(out_src), 135'(0));
        drain("single");

        // Repeat contention: last_grant is now 0, so in1 goes first.
        push_pkt(1'b1, 8'h23, 3);
        push_pkt(1'b0, 8'h22, 3);
        for (int i = 0; i < 3; i++) step(1'b1, mk(tg(i, 3), 8'h22, i), 1'b1, mk(tg(i, 3), 8'h23, i));
        drain("contend_b");

        // Oversize 9-word packet on in1 is dropped; the next 2-word one passes.
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, mk(tg(i, 9), 8'h30, i));
        chk("oversize_drop1", 135'(drop_cnt1), 135'(1));
        push_pkt(1'b1, 8'h31, 2);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, mk(tg(i, 2), 8'h31, i));
        drain("oversize_next");

        // Missing tail on in0: partial packet dropped, new head processed at once.
        push_pkt(1'b0, 8'h35, 2);
        step(1'b1, mk(2'b01, 8'h34, 0), 1'b0, '0);
        step(1'b1, mk(2'b00, 8'h34, 1), 1'b0, '0);
        step(1'b1, mk(2'b01, 8'h35, 0), 1'b0, '0);
        step(1'b1, mk(2'b10, 8'h35, 1), 1'b0, '0);
        chk("notail_drop0", 135'(drop_cnt0), 135'(1));
        drain("notail");

        // FIFO full: in1 keeps the output busy, third in0 head sees free=6 < 8.
        push_pkt(1'b1, 8'h40, 8);
        push_pkt(1'b0, 8'h50, 8);
        push_pkt(1'b1, 8'h41, 8);
        push_pkt(1'b0, 8'h51, 8);
        push_pkt(1'b0, 8'h60, 1);
        push_pkt(1'b0, 8'h61, 1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, mk(tg(i, 8), 8'h40, i));
        for (int i = 0; i < 8; i++) step(1'b1, mk(tg(i, 8), 8'h50, i), 1'b1, mk(tg(i, 8), 8'h41, i));
        for (int i = 0; i < 8; i++) step(1'b1, mk(tg(i, 8), 8'h51, i), 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b1, mk(tg(i, 8), 8'h52, i), 1'b0, '0);
        chk("full_drop0", 135'(drop_cnt0), 135'(2));
        chk("full_drop1", 135'(drop_cnt1), 135'(1));
        step(1'b1, mk(2'b11, 8'h60, 0), 1'b0, '0);
        step(1'b1, mk(2'b11, 8'h61, 0), 1'b0, '0);
        drain("full");

        // Reset during word 2 of a 5-word output; only word 1 is seen.
        exp_q.push_back({1'b0, mk(2'b01, 8'h70, 0)});
        for (int i = 0; i < 5; i++) step(1'b1, mk(tg(i, 5), 8'h70, i), 1'b0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid_w1_valid", 135'(out_valid), 135'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 135'(out_valid), 135'(0));
        chk("rstmid_drop0", 135'(drop_cnt0), 135'(0));
        chk("rstmid_drop1", 135'(drop_cnt1), 135'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rstmid_flushed", 135'(exp_q.size()), 135'(0));
        step(1'b1, mk(2'b00, 8'h70, 3), 1'b0, '0);
        step(1'b1, mk(2'b10, 8'h70, 4), 1'b0, '0);
        push_pkt(1'b0, 8'h71, 3);
        for (int i = 0; i < 3; i++) step(1'b1, mk(tg(i, 3), 8'h71, i), 1'b0, '0);
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
